// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with a valid/ready handshake, flush-to-bubble,
// an optional 2-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_reg #(
  parameter int                 WIDTH        = 96,
  parameter int                 SKID         = 1,
  parameter logic [WIDTH-1:0]   BUBBLE_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [WIDTH-1:0]       main_reg;
  logic                   ready;
  logic                   push;
  logic                   pop;
  logic [CNT_WIDTH-1:0]   stall_reg;

  assign out_valid   = (state_reg != EMPTY);
  assign out_data    = out_valid ? main_reg : BUBBLE_VALUE;
  assign occupancy   = state_reg;
  assign in_ready    = ready;
  assign stall_count = stall_reg;
  assign push        = in_valid & ready;
  assign pop         = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    state_t           state_next;
    logic [WIDTH-1:0] main_next;
    logic [WIDTH-1:0] skid_reg;
    logic [WIDTH-1:0] skid_next;
    logic             ready_reg;

    always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      case (state_reg)
        EMPTY: begin
          if (push) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_next = in_data;
          end else if (push) begin
            state_next = FULL;
            skid_next  = in_data;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_next = ONE;
            main_next  = skid_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
      if (flush) begin
        state_next = EMPTY;
      end
    end

    // in_ready is looked ahead from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk) begin
      if (!reset) begin
        state_reg <= EMPTY;
        ready_reg <= 1'b1;
      end else begin
        state_reg <= state_next;
        ready_reg <= (state_next != FULL);
      end
    end

    always_ff @(posedge clk) begin
      main_reg <= main_next;
      skid_reg <= skid_next;
    end

    assign ready = ready_reg;
  end else begin : g_single
    assign ready = (state_reg == EMPTY) | out_ready;

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_reg <= EMPTY;
      end else if (flush) begin
        state_reg <= EMPTY;
      end else if (push) begin
        state_reg <= ONE;
      end else if (pop) begin
        state_reg <= EMPTY;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        main_reg <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_reg <= '0;
    end else if (out_valid && !out_ready && !(&stall_reg)) begin
      stall_reg <= stall_reg + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline-stage register for the processor datapath (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries).
- Replaces fixed-width, always-load stage registers with a valid/ready handshake, stall back-pressure, flush (bubble insert) and an optional 2-entry skid buffer.
- The skid buffer registers the upstream ready path; it is selected by parameter.
- A saturating stall counter supports performance debug.

Parameters:
- WIDTH, 96, payload bits per entry (≥1).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- BUBBLE_VALUE, {WIDTH{1'b0}}, value driven on out_data whenever out_valid=0.
- CNT_WIDTH, 16, width of stall_count (≥1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- flush  input  1  synchronous, active-high; discards all held and incoming entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  entry available downstream.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload of oldest entry.
- occupancy  output  2  entries held (0..2; max 1 when SKID=0).
- stall_count  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Push = in_valid & in_ready at posedge. Pop = out_valid & out_ready at posedge. Data is never accepted when in_ready=0.
- Priority: reset > flush > push/pop.
- Reset (reset=0 at posedge):
  - occupancy=0, out_valid=0, out_data=BUBBLE_VALUE, stall_count=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - A push offered during reset is dropped.
- Latency: push into an empty stage gives out_valid=1 with that data on the next cycle. Throughput is 1 entry per cycle when out_ready=1.
- out_data equals BUBBLE_VALUE whenever out_valid=0; otherwise it is the oldest held entry. FIFO order is preserved.
- SKID=1 state machine (main reg M, skid reg S), where state = occupancy:
  - EMPTY(0): push -> ONE (M<=in_data).
  - ONE(1):
    - push & pop -> ONE (M<=in_data).
    - push only -> FULL (S<=in_data).
    - pop only -> EMPTY.
    - neither -> hold.
  - FULL(2): in_ready=0, so no push is possible. Pop -> ONE (M<=S). No pop -> hold.
  - in_ready is a flop: 1 exactly when the next state != FULL. No combinational path from out_ready to in_ready.
- SKID=0:
  - Single reg M. in_ready = !out_valid | out_ready (combinational).
  - push -> M<=in_data, out_valid=1. Pop without push -> out_valid=0.
- flush=1 at posedge:
  - occupancy->0, out_valid->0, out_data->BUBBLE_VALUE.
  - A concurrent push is discarded.
  - A concurrent pop counts as completed downstream.
  - in_ready=1 next cycle.
  - stall_count is unaffected.
- stall_count: +1 on each posedge with out_valid=1 and out_ready=0. Saturates at 2^CNT_WIDTH-1 with no wrap. Cleared only by reset.
- Reset mid-transfer: all held entries are lost with no further out_valid. Upstream must re-present its data.
- occupancy never exceeds 2 (SKID=1) or 1 (SKID=0). Pop from empty is impossible because out_valid=0.

Test Plan:
- Reset/idle, SKID=1:
  - Stimulus: reset=0 for 2 cycles with in_valid=1, in_data=0xAA; then reset=1.
  - Required: out_valid=0, out_data=0, occupancy=0 throughout; in_ready=1 after reset; 0xAA never appears on out_data.
- Streaming, SKID=1:
  - Stimulus: out_ready=1, push 0x1,0x2,0x3 on consecutive cycles.
  - Required: out_data=0x1,0x2,0x3 on cycles 1,2,3 after the first push; occupancy=1 throughout.
- Back-pressure, SKID=1:
  - Stimulus: out_ready=0, push 0x10 then 0x11; in_valid stays high with 0x12.
  - Required: occupancy=2, in_ready=0, 0x12 not accepted; stall_count increments each stalled cycle.
  - Stimulus: out_ready=1.
  - Required: out_data sequence 0x10,0x11,0x12 with no loss or duplication.
- Flush:
  - Stimulus: occupancy=2 holding 0x20,0x21; flush=1 with concurrent push 0x22.
  - Required: next cycle out_valid=0, out_data=BUBBLE_VALUE, occupancy=0, in_ready=1; 0x22 never output; stall_count unchanged.
- SKID=0, WIDTH=8:
  - Stimulus: out_ready=0 after one push of 0x5.
  - Required: in_ready=0 in the same cycle, combinationally.
  - Stimulus: out_ready=1 with in_valid=1, in_data=0x6.
  - Required: in_ready=1 in the same cycle; 0x6 appears next cycle.
- Saturation, CNT_WIDTH=3:
  - Stimulus: hold out_valid=1, out_ready=0 for 10 cycles.
  - Required: stall_count=7 and stays at 7.
  - Stimulus: reset.
  - Required: stall_count=0.
